router_fifo_pkt: RTL and testbench

Parametrised per-channel packet FIFO for the 1x3 router output side, a next-generation buffer between the router FSM/register stage and each destination port. It stores words with a header tag and supports concurrent read and write. It tracks how many words of the packet currently being read remain, and reports fill-level status including an almost-full threshold. One instance serves each output channel.

---
 rtl/router_fifo_pkt.sv | 165 ++++++++++++++++
 tb/tb_router_fifo_pkt.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_fifo_pkt.sv
// rtl/router_fifo_pkt.sv - per-channel packet FIFO with header tagging and packet tracking
//
// Purpose: stores DATA_WIDTH-bit words plus a header tag for one router output channel,
// supports concurrent read/write, tracks the words left in the packet being read and
// reports occupancy flags. Optional sticky misuse flag built when ROUTER_FIFO_ERR_EN is defined.
//
// Ports:
//   clock          in   rising-edge clock
//   resetn         in   synchronous active-low reset
//   soft_reset     in   synchronous channel flush
//   write_enb      in   write request
//   data_in        in   write data
//   lfd_state      in   word written this cycle is a packet header
//   read_enb       in   read request
//   data_out       out  registered read data
//   sop_out        out  header tag of the word on data_out
//   empty          out  occupancy == 0
//   full           out  occupancy == DEPTH
//   almost_full    out  occupancy >= AFULL_LEVEL
//   count          out  current occupancy
//   pkt_remaining  out  words left in the packet being read
//   err            out  sticky misuse flag (0 unless ROUTER_FIFO_ERR_EN)

module router_fifo_pkt #(
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 4,
   parameter int AFULL_LEVEL = 14,
   parameter int LEN_LSB     = 2
) (
   input  logic                           clock,
   input  logic                           resetn,
   input  logic                           soft_reset,
   input  logic                           write_enb,
   input  logic [DATA_WIDTH-1:0]          data_in,
   input  logic                           lfd_state,
   input  logic                           read_enb,
   output logic [DATA_WIDTH-1:0]          data_out,
   output logic                           sop_out,
   output logic                           empty,
   output logic                           full,
   output logic                           almost_full,
   output logic [ADDR_WIDTH:0]            count,
   output logic [DATA_WIDTH-LEN_LSB:0]    pkt_remaining,
   output logic                           err
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int PW    = DATA_WIDTH - LEN_LSB + 1;

   localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = 1;
   localparam logic [ADDR_WIDTH:0]   CNT_ONE   = 1;
   localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   CNT_AFULL = (ADDR_WIDTH+1)'(AFULL_LEVEL);
   localparam logic [PW-1:0]         PKT_ONE   = 1;

   logic [DATA_WIDTH:0]     mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]     count_q, count_d;
   logic [PW-1:0]           pkt_q, pkt_d;
   logic [DATA_WIDTH-1:0]   dout_q, dout_d;
   logic                    sop_q, sop_d;

   logic                    wr_acc, rd_acc;
   logic [DATA_WIDTH:0]     rd_word;

   assign empty       = (count_q == '0);
   assign full        = (count_q == CNT_DEPTH);
   assign almost_full = (count_q >= CNT_AFULL);
   assign count       = count_q;
   assign pkt_remaining = pkt_q;
   assign data_out    = dout_q;
   assign sop_out     = sop_q;

   // A write while full is dropped regardless of a same-cycle read.
   assign wr_acc  = write_enb & ~full;
   assign rd_acc  = read_enb & ~empty;
   assign rd_word = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      pkt_d    = pkt_q;
      dout_d   = dout_q;
      sop_d    = sop_q;

      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end

      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
         dout_d   = rd_word[DATA_WIDTH-1:0];
         sop_d    = rd_word[DATA_WIDTH];
         // Header loads length plus one trailing parity word.
         if (rd_word[DATA_WIDTH]) begin
            pkt_d = {1'b0, rd_word[DATA_WIDTH-1:LEN_LSB]} + PKT_ONE;
         end else if (pkt_q != '0) begin
            pkt_d = pkt_q - PKT_ONE;
         end
      end else if (pkt_q == '0) begin
         // Outside a packet the output bus idles at zero.
         dout_d = '0;
         sop_d  = 1'b0;
      end

      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      if (soft_reset) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         pkt_d    = '0;
         dout_d   = '0;
         sop_d    = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         pkt_q    <= '0;
         dout_q   <= '0;
         sop_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         pkt_q    <= pkt_d;
         dout_q   <= dout_d;
         sop_q    <= sop_d;
      end
   end

   // Storage is never cleared; an empty FIFO hides stale contents.
   always_ff @(posedge clock) begin
      if (resetn && !soft_reset && wr_acc) begin
         mem_q[wr_ptr_q] <= {lfd_state, data_in};
      end
   end

`ifdef ROUTER_FIFO_ERR_EN
   logic err_q;

   always_ff @(posedge clock) begin
      if (!resetn || soft_reset) begin
         err_q <= 1'b0;
      end else if ((write_enb & full) | (read_enb & empty)) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_router_fifo_pkt.sv
// tb/tb_router_fifo_pkt.sv - directed self-checking bench for router_fifo_pkt

module tb_router_fifo_pkt;

`ifdef ROUTER_FIFO_ERR_EN
   localparam logic ERR_EXP = 1'b1;
`else
   localparam logic ERR_EXP = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       resetn;
   logic       soft_reset;
   logic       write_enb;
   logic [7:0] data_in;
   logic       lfd_state;
   logic       read_enb;
   logic [7:0] data_out;
   logic       sop_out;
   logic       empty;
   logic       full;
   logic       almost_full;
   logic [4:0] count;
   logic [6:0] pkt_remaining;
   logic       err;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   router_fifo_pkt #(
      .DATA_WIDTH(8),
      .ADDR_WIDTH(4),
      .AFULL_LEVEL(14),
      .LEN_LSB(2)
   ) dut (
      .clock(clock),
      .resetn(resetn),
      .soft_reset(soft_reset),
      .write_enb(write_enb),
      .data_in(data_in),
      .lfd_state(lfd_state),
      .read_enb(read_enb),
      .data_out(data_out),
      .sop_out(sop_out),
      .empty(empty),
      .full(full),
      .almost_full(almost_full),
      .count(count),
      .pkt_remaining(pkt_remaining),
      .err(err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and land 1 time unit after the rising edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      soft_reset = 1'b0;
      write_enb  = 1'b0;
      read_enb   = 1'b0;
      lfd_state  = 1'b0;
      data_in    = 8'h00;
   endtask

   initial begin
      idle_inputs();
      resetn = 1'b0;
      step();
      step();

      // Reset state
      check("rst_data_out", data_out, 0);
      check("rst_sop", sop_out, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_afull", almost_full, 0);
      check("rst_count", count, 0);
      check("rst_pkt", pkt_remaining, 0);
      check("rst_err", err, 0);
      resetn = 1'b1;

      // Fill: 0x01..0x10, header tag on the first word
      for (int i = 1; i <= 16; i++) begin
         write_enb = 1'b1;
         data_in   = 8'(i);
         lfd_state = (i == 1);
         step();
         check($sformatf("fill_count_%0d", i), count, i);
         check($sformatf("fill_afull_%0d", i), almost_full, (i >= 14));
         check($sformatf("fill_full_%0d", i), full, (i == 16));
         check($sformatf("fill_empty_%0d", i), empty, 0);
      end
      check("fill_dout_idle", data_out, 0);

      // Overflow write is dropped
      write_enb = 1'b1;
      data_in   = 8'h11;
      lfd_state = 1'b0;
      step();
      check("ovf_count", count, 16);
      check("ovf_full", full, 1);
      check("ovf_err", err, ERR_EXP);
      write_enb = 1'b0;

      // Drain in order
      for (int i = 1; i <= 16; i++) begin
         read_enb = 1'b1;
         step();
         check($sformatf("drain_data_%0d", i), data_out, i);
         check($sformatf("drain_sop_%0d", i), sop_out, (i == 1));
         check($sformatf("drain_count_%0d", i), count, 16 - i);
         check($sformatf("drain_empty_%0d", i), empty, (i == 16));
         check($sformatf("drain_pkt_%0d", i), pkt_remaining, (i == 1) ? 1 : 0);
      end
      read_enb = 1'b0;
      step();
      check("drain_idle_dout", data_out, 0);
      check("drain_idle_sop", sop_out, 0);

      // Packet tracking: header 0x0C (length 3) + 4 untagged words
      write_enb = 1'b1;
      data_in   = 8'h0C;
      lfd_state = 1'b1;
      step();
      check("pkt_wr_to_rd_empty", empty, 0);
      lfd_state = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         data_in = 8'hA0 + 8'(i);
         step();
      end
      write_enb = 1'b0;
      check("pkt_count", count, 5);

      read_enb = 1'b1;
      step();
      check("pkt_hdr_data", data_out, 8'h0C);
      check("pkt_hdr_sop", sop_out, 1);
      check("pkt_rem_4", pkt_remaining, 4);
      step();
      check("pkt_w1_data", data_out, 8'hA1);
      check("pkt_w1_sop", sop_out, 0);
      check("pkt_rem_3", pkt_remaining, 3);
      // Stall inside a packet: output holds
      read_enb = 1'b0;
      step();
      check("pkt_stall_data", data_out, 8'hA1);
      check("pkt_stall_rem", pkt_remaining, 3);
      read_enb = 1'b1;
      step();
      check("pkt_w2_data", data_out, 8'hA2);
      check("pkt_rem_2", pkt_remaining, 2);
      step();
      check("pkt_w3_data", data_out, 8'hA3);
      check("pkt_rem_1", pkt_remaining, 1);
      step();
      check("pkt_w4_data", data_out, 8'hA4);
      check("pkt_rem_0", pkt_remaining, 0);
      check("pkt_empty", empty, 1);
      read_enb = 1'b0;
      step();
      check("pkt_end_dout", data_out, 0);

      // Simultaneous read/write at count=5 across pointer wrap
      write_enb = 1'b1;
      for (int i = 0; i < 5; i++) begin
         data_in = 8'h20 + 8'(i);
         step();
      end
      check("sim_pre_count", count, 5);
      read_enb = 1'b1;
      for (int k = 0; k < 10; k++) begin
         data_in = 8'h25 + 8'(k);
         step();
         check($sformatf("sim_count_%0d", k), count, 5);
         check($sformatf("sim_data_%0d", k), data_out, 8'h20 + 8'(k));
      end
      write_enb = 1'b0;
      read_enb  = 1'b0;
      step();
      check("sim_post_count", count, 5);
      check("sim_post_dout", data_out, 0);
      read_enb = 1'b1;
      step();
      check("sim_next_data", data_out, 8'h2A);
      read_enb = 1'b0;

      // Flush, which also clears a sticky error
      soft_reset = 1'b1;
      step();
      soft_reset = 1'b0;
      check("flush_count", count, 0);
      check("flush_err", err, 0);

      // Soft reset mid-packet: header 0x10 (length 4) + 9 words, read 3
      write_enb = 1'b1;
      data_in   = 8'h10;
      lfd_state = 1'b1;
      step();
      lfd_state = 1'b0;
      for (int i = 0; i < 9; i++) begin
         data_in = 8'hB0 + 8'(i);
         step();
      end
      write_enb = 1'b0;
      read_enb  = 1'b1;
      step();
      step();
      step();
      read_enb = 1'b0;
      check("sr_pre_count", count, 7);
      check("sr_pre_pkt", pkt_remaining, 3);
      check("sr_pre_data", data_out, 8'hB1);

      soft_reset = 1'b1;
      write_enb  = 1'b1;
      data_in    = 8'hFF;
      step();
      soft_reset = 1'b0;
      write_enb  = 1'b0;
      check("sr_count", count, 0);
      check("sr_empty", empty, 1);
      check("sr_pkt", pkt_remaining, 0);
      check("sr_dout", data_out, 0);
      check("sr_sop", sop_out, 0);
      check("sr_err", err, 0);
      step();
      check("sr_write_ignored", count, 0);

      // Underflow read
      read_enb = 1'b1;
      step();
      read_enb = 1'b0;
      check("udf_dout", data_out, 0);
      check("udf_count", count, 0);
      check("udf_empty", empty, 1);
      check("udf_err", err, ERR_EXP);
      step();
      check("udf_err_sticky", err, ERR_EXP);

      resetn = 1'b0;
      step();
      resetn = 1'b1;
      check("final_rst_err", err, 0);
      check("final_rst_empty", empty, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
